// File: rtl/pid_regs_pkg.sv
// Shared constants for the PID gain register bank.
//   CTRL_*_BIT : bit positions of the control word written to CTRL_ADDR
//   STAT_*_BIT : bit positions of the status word read back from CTRL_ADDR
//   DEF_*_ADDR : default register map placement
package pid_regs_pkg;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_REVERT_BIT = 1;

  localparam int unsigned STAT_DIRTY_BIT = 0;
  localparam int unsigned STAT_ERR_BIT   = 1;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h00;
  localparam logic [7:0] DEF_CTRL_ADDR = 8'h10;

endpackage

// File: rtl/pid_gain_slot.sv
// One gain slot: a shadow register written over I2C and an active register
// that feeds the PID core.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : load shadow from d
//   commit     : copy shadow into active
//   revert     : copy active back into shadow
//   d          : write data
//   shadow_q   : shadow register contents
//   active_q   : active register contents
module pid_gain_slot #(
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              commit,
  input  logic              revert,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] shadow_q,
  output logic [DATA_W-1:0] active_q
);

  logic [DATA_W-1:0] shadow_d;
  logic [DATA_W-1:0] active_d;

  // wr_en and commit/revert are mutually exclusive: one pointer, one address.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) begin
      shadow_d = d;
    end else if (revert) begin
      shadow_d = active_q;
    end
    if (commit) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/pid_gain_regbank.sv
// PID gain register bank behind an I2C slave byte interface.
// Shadow gains are written over I2C; writing CTRL commits all shadows to the
// active set in one edge so the PID core never sees a partial update.
//   clk, rst             : clock, synchronous active-high reset
//   ena                  : block enable; strobes and addr_set ignored when low
//   addr_set, addr_in    : load the address pointer
//   wr_strobe, wr_data   : write at the pointer (auto-increments in gain range)
//   rd_strobe            : read at the pointer
//   rd_data, rd_valid    : registered read data and its 1-cycle valid
//   gains                : active gains, slot i at gains[i*DATA_W +: DATA_W]
//   commit_pls           : pulse in the first cycle the new gains are visible
//   err                  : sticky error flag, cleared by a CTRL read
module pid_gain_regbank
  import pid_regs_pkg::*;
#(
  parameter int unsigned       NUM_GAINS = 3,
  parameter int unsigned       DATA_W    = 6,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEF_CTRL_ADDR)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          addr_set,
  input  logic [ADDR_W-1:0]             addr_in,
  input  logic                          wr_strobe,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_strobe,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [NUM_GAINS*DATA_W-1:0]   gains,
  output logic                          commit_pls,
  output logic                          err
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              commit_pls_q, commit_pls_d;
  logic              err_q, err_d;
  logic              dirty_q, dirty_d;

  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W:0]   diff;
  logic [ADDR_W-1:0] off;
  logic              is_gain, is_ctrl;
  logic              wr_acc, rd_acc, collide, any_acc;
  logic              wr_ctrl, do_commit, do_revert;
  logic [NUM_GAINS-1:0] slot_wr;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] shadow [NUM_GAINS];
  logic [DATA_W-1:0] active [NUM_GAINS];

  // Address decode. A same-cycle addr_set redirects the strobe to addr_in.
  // The extra diff bit flags addresses below BASE_ADDR.
  always_comb begin
    eff_addr  = addr_set ? addr_in : ptr_q;
    diff      = {1'b0, eff_addr} - {1'b0, BASE_ADDR};
    off       = diff[ADDR_W-1:0];
    is_gain   = !diff[ADDR_W] && (off < ADDR_W'(NUM_GAINS));
    is_ctrl   = (eff_addr == CTRL_ADDR);
    wr_acc    = ena && wr_strobe;
    rd_acc    = ena && rd_strobe && !wr_strobe;
    collide   = ena && wr_strobe && rd_strobe;
    any_acc   = ena && (wr_strobe || rd_strobe);
    wr_ctrl   = wr_acc && is_ctrl;
    do_commit = wr_ctrl && wr_data[CTRL_COMMIT_BIT];
    do_revert = wr_ctrl && wr_data[CTRL_REVERT_BIT] && !wr_data[CTRL_COMMIT_BIT];
    for (int i = 0; i < NUM_GAINS; i++) begin
      slot_wr[i] = wr_acc && is_gain && (off == ADDR_W'(i));
    end
  end

  // Read mux; status is sampled pre-clear.
  always_comb begin
    status                 = '0;
    status[STAT_DIRTY_BIT] = dirty_q;
    status[STAT_ERR_BIT]   = err_q;
    rd_mux                 = '0;
    if (is_ctrl) begin
      rd_mux = status;
    end else if (is_gain) begin
      for (int i = 0; i < NUM_GAINS; i++) begin
        if (off == ADDR_W'(i)) rd_mux = shadow[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ena && addr_set) ptr_d = addr_in;
    // Auto-increment only inside the gain range; the last slot wraps.
    if (any_acc && is_gain) begin
      ptr_d = (off == ADDR_W'(NUM_GAINS - 1)) ? BASE_ADDR : BASE_ADDR + off + ADDR_W'(1);
    end

    dirty_d = dirty_q;
    if (|slot_wr) dirty_d = 1'b1;
    if (do_commit || do_revert) dirty_d = 1'b0;

    err_d = err_q;
    if (rd_acc && is_ctrl) err_d = 1'b0;
    if (((wr_acc || rd_acc) && !is_gain && !is_ctrl) || collide) err_d = 1'b1;

    rd_valid_d   = rd_acc;
    rd_data_d    = rd_acc ? rd_mux : rd_data_q;
    commit_pls_d = do_commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      commit_pls_q <= 1'b0;
      err_q        <= 1'b0;
      dirty_q      <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      commit_pls_q <= commit_pls_d;
      err_q        <= err_d;
      dirty_q      <= dirty_d;
    end
  end

  for (genvar g = 0; g < NUM_GAINS; g++) begin : g_slot
    pid_gain_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (slot_wr[g]),
      .commit   (do_commit),
      .revert   (do_revert),
      .d        (wr_data),
      .shadow_q (shadow[g]),
      .active_q (active[g])
    );
    assign gains[g*DATA_W +: DATA_W] = active[g];
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign commit_pls = commit_pls_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pid_gain_regbank.sv
module tb_pid_gain_regbank;

  localparam int DW  = 6;
  localparam int NG  = 3;
  localparam int WDW = 12;
  localparam int WNG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT.
  logic             rst, ena, addr_set, wr_strobe, rd_strobe;
  logic [7:0]       addr_in;
  logic [DW-1:0]    wr_data, rd_data;
  logic             rd_valid, commit_pls, err;
  logic [NG*DW-1:0] gains;

  // Wide DUT.
  logic              w_rst, w_ena, w_addr_set, w_wr_strobe, w_rd_strobe;
  logic [7:0]        w_addr_in;
  logic [WDW-1:0]    w_wr_data, w_rd_data;
  logic              w_rd_valid, w_commit_pls, w_err;
  logic [WNG*WDW-1:0] w_gains;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0]  exp_q[$];
  logic [WDW-1:0] wexp_q[$];
  logic [DW-1:0]  mon_e;
  logic [WDW-1:0] wmon_e;

  pid_gain_regbank #(
    .NUM_GAINS (NG),
    .DATA_W    (DW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .addr_set   (addr_set),
    .addr_in    (addr_in),
    .wr_strobe  (wr_strobe),
    .wr_data    (wr_data),
    .rd_strobe  (rd_strobe),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .gains      (gains),
    .commit_pls (commit_pls),
    .err        (err)
  );

  pid_gain_regbank #(
    .NUM_GAINS (WNG),
    .DATA_W    (WDW)
  ) u_dut_wide (
    .clk        (clk),
    .rst        (w_rst),
    .ena        (w_ena),
    .addr_set   (w_addr_set),
    .addr_in    (w_addr_in),
    .wr_strobe  (w_wr_strobe),
    .wr_data    (w_wr_data),
    .rd_strobe  (w_rd_strobe),
    .rd_data    (w_rd_data),
    .rd_valid   (w_rd_valid),
    .gains      (w_gains),
    .commit_pls (w_commit_pls),
    .err        (w_err)
  );

  // Scoreboard: every rd_valid pops one expected read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid with rd_data=%h, required no rd_valid", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_data !== mon_e) begin
          n_fail++;
          $display("FAIL rd_data: got %h, required %h", rd_data, mon_e);
        end
      end
    end
    if (w_rd_valid === 1'b1) begin
      n_cmp++;
      if (wexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wide_rd_unexpected: got rd_data=%h, required no rd_valid", w_rd_data);
      end else begin
        wmon_e = wexp_q.pop_front();
        if (w_rd_data !== wmon_e) begin
          n_fail++;
          $display("FAIL wide_rd_data: got %h, required %h", w_rd_data, wmon_e);
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic as, input logic [7:0] a, input logic wr,
                    input logic [DW-1:0] wd, input logic rd, input logic [DW-1:0] e);
    addr_set = as; addr_in = a; wr_strobe = wr; wr_data = wd; rd_strobe = rd;
    if (rd && !wr && ena) exp_q.push_back(e);
    @(posedge clk); #1;
    addr_set = 1'b0; wr_strobe = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic wop(input logic as, input logic [7:0] a, input logic wr,
                     input logic [WDW-1:0] wd, input logic rd, input logic [WDW-1:0] e);
    w_addr_set = as; w_addr_in = a; w_wr_strobe = wr; w_wr_data = wd; w_rd_strobe = rd;
    if (rd && !wr && w_ena) wexp_q.push_back(e);
    @(posedge clk); #1;
    w_addr_set = 1'b0; w_wr_strobe = 1'b0; w_rd_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(); idle();
    n_cmp++; if (gains !== '0) begin n_fail++; $display("FAIL reset_gains: got %h, required 0", gains); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
    n_cmp++; if (commit_pls !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b, required 0", commit_pls); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 0", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_burst_write();
    op(1'b1, 8'h00, 1'b1, 6'd5, 1'b0, '0);
    op(1'b0, 8'h00, 1'b1, 6'd9, 1'b0, '0);
    op(1'b0, 8'h00, 1'b1, 6'd3, 1'b0, '0);
    n_cmp++; if (gains !== '0) begin n_fail++; $display("FAIL burst_gains_held: got %h, required 0", gains); end
    op(1'b0, 8'h00, 1'b0, '0, 1'b1, 6'd5);     // pointer wrapped to slot 0
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b01);    // dirty
    idle();
  endtask

  task automatic test_commit();
    op(1'b1, 8'h10, 1'b1, 6'h01, 1'b0, '0);
    n_cmp++; if (commit_pls !== 1'b1) begin n_fail++; $display("FAIL commit_pls_high: got %b, required 1", commit_pls); end
    n_cmp++; if (gains !== {6'd3, 6'd9, 6'd5}) begin n_fail++; $display("FAIL commit_gains: got %h, required %h", gains, {6'd3, 6'd9, 6'd5}); end
    idle();
    n_cmp++; if (commit_pls !== 1'b0) begin n_fail++; $display("FAIL commit_pls_width: got %b, required 0", commit_pls); end
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b00);
    idle();
  endtask

  task automatic test_commit_revert();
    op(1'b1, 8'h01, 1'b1, 6'd7, 1'b0, '0);
    op(1'b1, 8'h10, 1'b1, 6'h03, 1'b0, '0);
    n_cmp++; if (commit_pls !== 1'b1) begin n_fail++; $display("FAIL both_commit_pls: got %b, required 1", commit_pls); end
    n_cmp++; if (gains !== {6'd3, 6'd7, 6'd5}) begin n_fail++; $display("FAIL both_gains: got %h, required %h", gains, {6'd3, 6'd7, 6'd5}); end
    op(1'b1, 8'h01, 1'b1, 6'd2, 1'b0, '0);
    op(1'b1, 8'h10, 1'b1, 6'h02, 1'b0, '0);
    n_cmp++; if (commit_pls !== 1'b0) begin n_fail++; $display("FAIL revert_commit_pls: got %b, required 0", commit_pls); end
    n_cmp++; if (gains !== {6'd3, 6'd7, 6'd5}) begin n_fail++; $display("FAIL revert_gains: got %h, required %h", gains, {6'd3, 6'd7, 6'd5}); end
    op(1'b1, 8'h01, 1'b0, '0, 1'b1, 6'd7);
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b00);
    idle();
  endtask

  task automatic test_unmapped();
    op(1'b1, 8'h05, 1'b0, '0, 1'b1, 6'd0);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %b, required 1", err); end
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b10);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, required 0", err); end
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b00);
    idle();
  endtask

  task automatic test_back_to_back();
    op(1'b1, 8'h00, 1'b1, 6'd4, 1'b1, '0);     // read dropped, no push
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL collide_err: got %b, required 1", err); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL collide_rd_valid: got %b, required 0", rd_valid); end
    op(1'b0, 8'h00, 1'b0, '0, 1'b1, 6'd7);     // pointer advanced once to slot 1
    op(1'b1, 8'h00, 1'b0, '0, 1'b1, 6'd4);
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b11);
    idle();
  endtask

  task automatic test_ena_and_reset();
    ena = 1'b0;
    op(1'b1, 8'h02, 1'b1, 6'h3f, 1'b0, '0);
    op(1'b0, 8'h00, 1'b0, '0, 1'b1, '0);
    op(1'b1, 8'h10, 1'b1, 6'h01, 1'b0, '0);
    n_cmp++; if (commit_pls !== 1'b0) begin n_fail++; $display("FAIL ena_commit_pls: got %b, required 0", commit_pls); end
    n_cmp++; if (gains !== {6'd3, 6'd7, 6'd5}) begin n_fail++; $display("FAIL ena_gains: got %h, required %h", gains, {6'd3, 6'd7, 6'd5}); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ena_rd_valid: got %b, required 0", rd_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ena_err: got %b, required 0", err); end
    ena = 1'b1;
    op(1'b0, 8'h00, 1'b0, '0, 1'b1, 6'b01);    // pointer still at CTRL
    op(1'b1, 8'h02, 1'b0, '0, 1'b1, 6'd3);     // shadow 2 untouched
    // Reset lands mid-burst with a read strobe in the same cycle.
    op(1'b1, 8'h00, 1'b1, 6'h11, 1'b0, '0);
    rst = 1'b1; rd_strobe = 1'b1;
    idle();
    rd_strobe = 1'b0;
    n_cmp++; if (gains !== '0) begin n_fail++; $display("FAIL rst_mid_gains: got %h, required 0", gains); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_valid: got %b, required 0", rd_valid); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_mid_rd_data: got %h, required 0", rd_data); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b, required 0", err); end
    rst = 1'b0;
    op(1'b1, 8'h00, 1'b0, '0, 1'b1, 6'd0);
    op(1'b1, 8'h10, 1'b0, '0, 1'b1, 6'b00);
    idle();
  endtask

  task automatic test_wide();
    logic [WNG*WDW-1:0] exp_g;
    exp_g = {12'h800, 12'h001, 12'hFFF, 12'h123, 12'hABC};
    w_rst = 1'b1;
    idle(); idle();
    n_cmp++; if (w_gains !== '0) begin n_fail++; $display("FAIL wide_reset_gains: got %h, required 0", w_gains); end
    w_rst = 1'b0;
    wop(1'b1, 8'h00, 1'b1, 12'hABC, 1'b0, '0);
    wop(1'b0, 8'h00, 1'b1, 12'h123, 1'b0, '0);
    wop(1'b0, 8'h00, 1'b1, 12'hFFF, 1'b0, '0);
    wop(1'b0, 8'h00, 1'b1, 12'h001, 1'b0, '0);
    wop(1'b0, 8'h00, 1'b1, 12'h800, 1'b0, '0);
    n_cmp++; if (w_gains !== '0) begin n_fail++; $display("FAIL wide_gains_held: got %h, required 0", w_gains); end
    wop(1'b0, 8'h00, 1'b0, '0, 1'b1, 12'hABC);
    wop(1'b1, 8'h10, 1'b0, '0, 1'b1, 12'h001);
    wop(1'b1, 8'h10, 1'b1, 12'h001, 1'b0, '0);
    n_cmp++; if (w_commit_pls !== 1'b1) begin n_fail++; $display("FAIL wide_commit_pls: got %b, required 1", w_commit_pls); end
    n_cmp++; if (w_gains !== exp_g) begin n_fail++; $display("FAIL wide_commit_gains: got %h, required %h", w_gains, exp_g); end
    idle();
    n_cmp++; if (w_commit_pls !== 1'b0) begin n_fail++; $display("FAIL wide_commit_width: got %b, required 0", w_commit_pls); end
    wop(1'b1, 8'h10, 1'b0, '0, 1'b1, 12'h000);
    idle();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; addr_set = 1'b0; addr_in = '0;
    wr_strobe = 1'b0; wr_data = '0; rd_strobe = 1'b0;
    w_rst = 1'b1; w_ena = 1'b1; w_addr_set = 1'b0; w_addr_in = '0;
    w_wr_strobe = 1'b0; w_wr_data = '0; w_rd_strobe = 1'b0;
    #1;
    test_reset();
    test_burst_write();
    test_commit();
    test_commit_revert();
    test_unmapped();
    test_back_to_back();
    test_ena_and_reset();
    test_wide();
    idle(); idle(); idle();
    // Any expected read still queued never produced rd_valid.
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rd_missing: got %0d reads outstanding, required 0", exp_q.size()); end
    n_cmp++; if (wexp_q.size() != 0) begin n_fail++; $display("FAIL wide_rd_missing: got %0d reads outstanding, required 0", wexp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
